// File: rtl/math_div_seq_ctrl.sv
// math_div_seq_ctrl
// Runs NUM_CH dividends through an external AXI-Stream divider one at a time,
// using one shared divisor, and keeps the quotients in per-channel registers.
// A zero divisor skips the divider and forces all-ones results. A channel that
// does not return a result in time ends the run and its result is forced to
// all ones.
module math_div_seq_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int DIVIDEND_W  = 32,
  parameter int DIVISOR_W   = 16,
  parameter int QUOT_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         iTRIG,
  input  logic [NUM_CH*DIVIDEND_W-1:0] iDIVIDEND,
  input  logic [DIVISOR_W-1:0]         iDIVISOR,
  output logic [DIVIDEND_W-1:0]        oDIVIDEND_TDATA,
  output logic                         oDIVIDEND_TVALID,
  input  logic                         iDIVIDEND_TREADY,
  output logic [DIVISOR_W-1:0]         oDIVISOR_TDATA,
  output logic                         oDIVISOR_TVALID,
  input  logic                         iDIVISOR_TREADY,
  input  logic [QUOT_W-1:0]            iDOUT_TDATA,
  input  logic                         iDOUT_TVALID,
  output logic [NUM_CH*QUOT_W-1:0]     oQUOT,
  output logic                         oBUSY,
  output logic                         oDONE,
  output logic                         oDIVZERO,
  output logic                         oTIMEOUT
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic                           r_trig_q;
  logic [NUM_CH*DIVIDEND_W-1:0]   r_dividend;   // channel in use always sits at the bottom
  logic [DIVISOR_W-1:0]           r_divisor;
  logic [CH_W-1:0]                r_ch;
  logic [TCNT_W-1:0]              r_tcnt;
  logic [NUM_CH*QUOT_W-1:0]       r_quot;
  logic                           r_dvd_tvalid;
  logic                           r_dvs_tvalid;
  logic                           r_done;
  logic                           r_divzero;
  logic                           r_timeout;

  logic w_start;
  logic w_divzero;
  logic w_active;
  logic w_capture;
  logic w_timeout;
  logic w_last;
  logic w_dvd_hs;
  logic w_dvs_hs;
  logic w_issue_done;
  logic w_dvd_tvalid_nxt;
  logic w_dvs_tvalid_nxt;

  assign w_start      = iTRIG & ~r_trig_q & (r_state == S_IDLE);
  assign w_divzero    = (iDIVISOR == {DIVISOR_W{1'b0}});
  assign w_active     = (r_state == S_ISSUE) | (r_state == S_WAIT);
  assign w_capture    = (r_state == S_WAIT) & iDOUT_TVALID;
  // a result arriving on the last allowed cycle still wins over the timeout
  assign w_timeout    = w_active & ~w_capture & (r_tcnt == TCNT_MAX);
  assign w_last       = (r_ch == LAST_CH);
  assign w_dvd_hs     = r_dvd_tvalid & iDIVIDEND_TREADY;
  assign w_dvs_hs     = r_dvs_tvalid & iDIVISOR_TREADY;
  assign w_issue_done = (~r_dvd_tvalid | w_dvd_hs) & (~r_dvs_tvalid | w_dvs_hs);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = w_start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next_state = w_divzero ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (w_timeout) begin
          w_next_state = S_DONE;
        end else if (w_issue_done) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (w_capture) begin
          w_next_state = w_last ? S_DONE : S_ISSUE;
        end else if (w_timeout) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next values of the stream TVALIDs for the registered outputs
  always_comb begin
    w_dvd_tvalid_nxt = 1'b0;
    w_dvs_tvalid_nxt = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_dvd_tvalid_nxt = ~w_divzero;
        w_dvs_tvalid_nxt = ~w_divzero;
      end
      S_ISSUE: begin
        if (w_timeout) begin
          w_dvd_tvalid_nxt = 1'b0;
          w_dvs_tvalid_nxt = 1'b0;
        end else begin
          w_dvd_tvalid_nxt = r_dvd_tvalid & ~iDIVIDEND_TREADY;
          w_dvs_tvalid_nxt = r_dvs_tvalid & ~iDIVISOR_TREADY;
        end
      end
      S_WAIT: begin
        if (w_capture && !w_last) begin
          w_dvd_tvalid_nxt = 1'b1;
          w_dvs_tvalid_nxt = 1'b1;
        end else begin
          w_dvd_tvalid_nxt = 1'b0;
          w_dvs_tvalid_nxt = 1'b0;
        end
      end
      default: begin
        w_dvd_tvalid_nxt = 1'b0;
        w_dvs_tvalid_nxt = 1'b0;
      end
    endcase
  end

  // Trigger history for rising-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_trig_q <= 1'b0;
    end else begin
      r_trig_q <= iTRIG;
    end
  end

  // Operand latches, channel pointer, timeout counter, results and flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dividend   <= {(NUM_CH*DIVIDEND_W){1'b0}};
      r_divisor    <= {DIVISOR_W{1'b0}};
      r_ch         <= {CH_W{1'b0}};
      r_tcnt       <= {TCNT_W{1'b0}};
      r_quot       <= {(NUM_CH*QUOT_W){1'b0}};
      r_dvd_tvalid <= 1'b0;
      r_dvs_tvalid <= 1'b0;
      r_done       <= 1'b0;
      r_divzero    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_dvd_tvalid <= w_dvd_tvalid_nxt;
      r_dvs_tvalid <= w_dvs_tvalid_nxt;
      r_done       <= (r_state == S_DONE);
      if (r_state == S_LOAD) begin
        r_dividend <= iDIVIDEND;
        r_divisor  <= iDIVISOR;
        r_ch       <= {CH_W{1'b0}};
        r_tcnt     <= {TCNT_W{1'b0}};
        r_timeout  <= 1'b0;
        r_divzero  <= w_divzero;
        if (w_divzero) begin
          r_quot <= {(NUM_CH*QUOT_W){1'b1}};
        end else begin
          r_quot <= r_quot;
        end
      end else if (w_capture) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (int'(r_ch) == k) begin
            r_quot[k*QUOT_W +: QUOT_W] <= iDOUT_TDATA;
          end
        end
        r_tcnt <= {TCNT_W{1'b0}};
        if (!w_last) begin
          r_ch       <= r_ch + CH_W'(1);
          r_dividend <= r_dividend >> DIVIDEND_W;
        end
      end else if (w_timeout) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (int'(r_ch) == k) begin
            r_quot[k*QUOT_W +: QUOT_W] <= {QUOT_W{1'b1}};
          end
        end
        r_tcnt    <= {TCNT_W{1'b0}};
        r_timeout <= 1'b1;
      end else if (w_active) begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end else begin
        r_tcnt <= r_tcnt;
      end
    end
  end

  assign oDIVIDEND_TDATA  = r_dividend[DIVIDEND_W-1:0];
  assign oDIVIDEND_TVALID = r_dvd_tvalid;
  assign oDIVISOR_TDATA   = r_divisor;
  assign oDIVISOR_TVALID  = r_dvs_tvalid;
  assign oQUOT            = r_quot;
  assign oBUSY            = (r_state != S_IDLE);
  assign oDONE            = r_done;
  assign oDIVZERO         = r_divzero;
  assign oTIMEOUT         = r_timeout;

endmodule

// File: tb/tb_math_div_seq_ctrl.sv
// Bench for math_div_seq_ctrl: directed runs with hand-computed quotients.
// Expected results are queued when a run is started; a monitor pops and
// compares them whenever oDONE is seen. A small divider model answers the
// streams one cycle after each input handshake.
module tb_math_div_seq_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        iTRIG;
  logic [63:0] iDIVIDEND;
  logic [15:0] iDIVISOR;
  logic [31:0] oDIVIDEND_TDATA;
  logic        oDIVIDEND_TVALID;
  logic        iDIVIDEND_TREADY;
  logic [15:0] oDIVISOR_TDATA;
  logic        oDIVISOR_TVALID;
  logic        iDIVISOR_TREADY;
  logic [31:0] iDOUT_TDATA;
  logic        iDOUT_TVALID;
  logic [63:0] oQUOT;
  logic        oBUSY;
  logic        oDONE;
  logic        oDIVZERO;
  logic        oTIMEOUT;

  math_div_seq_ctrl #(
    .NUM_CH(2), .DIVIDEND_W(32), .DIVISOR_W(16), .QUOT_W(32), .TIMEOUT_CYC(8)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .iTRIG(iTRIG), .iDIVIDEND(iDIVIDEND), .iDIVISOR(iDIVISOR),
    .oDIVIDEND_TDATA(oDIVIDEND_TDATA), .oDIVIDEND_TVALID(oDIVIDEND_TVALID),
    .iDIVIDEND_TREADY(iDIVIDEND_TREADY), .oDIVISOR_TDATA(oDIVISOR_TDATA),
    .oDIVISOR_TVALID(oDIVISOR_TVALID), .iDIVISOR_TREADY(iDIVISOR_TREADY),
    .iDOUT_TDATA(iDOUT_TDATA), .iDOUT_TVALID(iDOUT_TVALID), .oQUOT(oQUOT),
    .oBUSY(oBUSY), .oDONE(oDONE), .oDIVZERO(oDIVZERO), .oTIMEOUT(oTIMEOUT)
  );

  typedef struct {
    logic [63:0] q;
    bit          dz;
    bit          tmo;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // divider model controls (written by stimulus only)
  bit   skew_mode = 1'b0;
  bit   drop_ch1  = 1'b0;
  // divider model observations (written by model only)
  int   tv_cycles   = 0;
  int   dvd_only    = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // scoreboard monitor: compare on every oDONE pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (oDONE === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          chk("quot_ch0", {32'd0, oQUOT[31:0]}, {32'd0, e.q[31:0]});
          chk("quot_ch1", {32'd0, oQUOT[63:32]}, {32'd0, e.q[63:32]});
          chk("divzero", {63'd0, oDIVZERO}, {63'd0, e.dz});
          chk("timeout", {63'd0, oTIMEOUT}, {63'd0, e.tmo});
          chk("busy_at_done", {63'd0, oBUSY}, 64'd0);
        end
      end
    end
  end

  // divider model: drives readies and returns a/b one cycle after input handshake
  initial begin
    bit          got_a, got_b, pend, pend_drop, prev_va, prev_ha, prev_vb, prev_hb, ha, hb;
    logic [31:0] a, pend_q, prev_da;
    logic [15:0] b, prev_db;
    int          vcnt, n_res;
    got_a = 1'b0; got_b = 1'b0; pend = 1'b0; pend_drop = 1'b0;
    prev_va = 1'b0; prev_ha = 1'b0; prev_vb = 1'b0; prev_hb = 1'b0;
    a = 32'd0; b = 16'd0; pend_q = 32'd0; prev_da = 32'd0; prev_db = 16'd0;
    vcnt = 0; n_res = 0;
    iDIVIDEND_TREADY = 1'b1;
    iDIVISOR_TREADY  = 1'b1;
    iDOUT_TVALID     = 1'b0;
    iDOUT_TDATA      = 32'd0;
    forever begin
      @(negedge CLK);
      if (!RST_N || !oBUSY) begin
        got_a = 1'b0; got_b = 1'b0; n_res = 0; vcnt = 0;
        prev_va = 1'b0; prev_vb = 1'b0;
        if (!RST_N) pend = 1'b0;
      end
      iDOUT_TVALID = 1'b0;
      if (pend) begin
        pend = 1'b0;
        if (!pend_drop) begin
          iDOUT_TVALID = 1'b1;
          iDOUT_TDATA  = pend_q;
        end
      end
      if (prev_va && !prev_ha && oDIVIDEND_TVALID)
        chk("dvd_tdata_stable", {32'd0, oDIVIDEND_TDATA}, {32'd0, prev_da});
      if (prev_vb && !prev_hb && oDIVISOR_TVALID)
        chk("dvs_tdata_stable", {48'd0, oDIVISOR_TDATA}, {48'd0, prev_db});
      if (oDIVIDEND_TVALID || oDIVISOR_TVALID) tv_cycles++;
      if (oDIVIDEND_TVALID && !oDIVISOR_TVALID) dvd_only++;
      vcnt = oDIVIDEND_TVALID ? vcnt + 1 : 0;
      iDIVIDEND_TREADY = skew_mode ? (vcnt >= 4) : 1'b1;
      iDIVISOR_TREADY  = 1'b1;
      ha = oDIVIDEND_TVALID && iDIVIDEND_TREADY;
      hb = oDIVISOR_TVALID && iDIVISOR_TREADY;
      if (ha) begin got_a = 1'b1; a = oDIVIDEND_TDATA; end
      if (hb) begin got_b = 1'b1; b = oDIVISOR_TDATA; end
      if (got_a && got_b) begin
        pend      = 1'b1;
        pend_q    = a / {16'd0, b};
        pend_drop = drop_ch1 && (n_res == 1);
        n_res++;
        got_a = 1'b0;
        got_b = 1'b0;
      end
      prev_va = oDIVIDEND_TVALID; prev_ha = ha; prev_da = oDIVIDEND_TDATA;
      prev_vb = oDIVISOR_TVALID;  prev_hb = hb; prev_db = oDIVISOR_TDATA;
    end
  end

  // one run: queue expectation, raise trigger, check oDONE arrives on the expected cycle
  task automatic run(input logic [31:0] d0, input logic [31:0] d1, input logic [15:0] dv,
                     input logic [31:0] q0, input logic [31:0] q1, input bit dz, input bit tmo,
                     input int exp_cyc, input bit toggle, input bit hold, input string nm);
    exp_t e;
    bit   seen;
    @(negedge CLK);
    iDIVIDEND = {d1, d0};
    iDIVISOR  = dv;
    e.q = {q1, q0}; e.dz = dz; e.tmo = tmo;
    sb.push_back(e);
    iTRIG = 1'b1;
    seen  = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge CLK);
      if (toggle && c == 2) begin
        iTRIG     = 1'b0;
        iDIVIDEND = 64'hDEAD_BEEF_0BAD_F00D;
        iDIVISOR  = 16'h0000;
      end
      if (toggle && c == 3) iTRIG = 1'b1;
      if (oDONE === 1'b1) begin
        seen = 1'b1;
        chk({nm, "_done_cycle"}, 64'(c), 64'(exp_cyc));
        break;
      end
    end
    if (!seen) chk({nm, "_done_seen"}, 64'd0, 64'd1);
    if (!hold) iTRIG = 1'b0;
  endtask

  initial begin
    int tv0, dvo0, busy_cnt;
    RST_N     = 1'b0;
    iTRIG     = 1'b0;
    iDIVIDEND = 64'd0;
    iDIVISOR  = 16'd0;
    #12;
    chk("rst_quot", oQUOT, 64'd0);
    chk("rst_flags", {60'd0, oBUSY, oDONE, oDIVZERO, oTIMEOUT}, 64'd0);
    chk("rst_tvalid", {62'd0, oDIVIDEND_TVALID, oDIVISOR_TVALID}, 64'd0);
    chk("rst_tdata", {16'd0, oDIVIDEND_TDATA, oDIVISOR_TDATA}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // basic two-channel run: 100/10, 250/10
    run(32'd100, 32'd250, 16'd10, 32'd10, 32'd25, 1'b0, 1'b0, 7, 1'b0, 1'b0, "basic");

    // dividend ready lags divisor ready by three cycles on each channel
    skew_mode = 1'b1;
    dvo0 = dvd_only;
    run(32'd1000, 32'd77, 16'd7, 32'd142, 32'd11, 1'b0, 1'b0, 13, 1'b0, 1'b0, "skew");
    chk("skew_dvs_first_cycles", 64'(dvd_only - dvo0), 64'd6);
    skew_mode = 1'b0;

    // zero divisor: no stream traffic, all ones, sticky divzero
    tv0 = tv_cycles;
    run(32'd7, 32'd9, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 3, 1'b0, 1'b0, "divzero");
    chk("divzero_no_tvalid", 64'(tv_cycles - tv0), 64'd0);

    // channel 1 never answers
    drop_ch1 = 1'b1;
    run(32'd50, 32'd60, 16'd5, 32'd10, 32'hFFFF_FFFF, 1'b0, 1'b1, 13, 1'b0, 1'b0, "timeout");
    drop_ch1 = 1'b0;

    // good run clears the timeout flag
    run(32'd81, 32'd18, 16'd9, 32'd9, 32'd2, 1'b0, 1'b0, 7, 1'b0, 1'b0, "recover");

    // extra trigger edge and input changes while busy, trigger held after done
    run(32'd65535, 32'd4096, 16'd256, 32'd255, 32'd16, 1'b0, 1'b0, 7, 1'b1, 1'b1, "busy_edges");
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (oBUSY) busy_cnt++;
    end
    chk("held_trig_no_restart", 64'(busy_cnt), 64'd0);
    iTRIG = 1'b0;
    run(32'hFFFF_FFFF, 32'd65535, 16'hFFFF, 32'h0001_0001, 32'd1, 1'b0, 1'b0, 7, 1'b0, 1'b0, "retrig");

    // reset while waiting for the divider
    @(negedge CLK);
    iDIVIDEND = {32'd30, 32'd20};
    iDIVISOR  = 16'd4;
    iTRIG     = 1'b1;
    repeat (3) @(negedge CLK);
    chk("pre_reset_busy", {63'd0, oBUSY}, 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrun_rst_quot", oQUOT, 64'd0);
    chk("midrun_rst_flags", {60'd0, oBUSY, oDONE, oDIVZERO, oTIMEOUT}, 64'd0);
    chk("midrun_rst_tvalid", {62'd0, oDIVIDEND_TVALID, oDIVISOR_TVALID}, 64'd0);
    chk("midrun_rst_tdata", {16'd0, oDIVIDEND_TDATA, oDIVISOR_TDATA}, 64'd0);
    iTRIG = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    run(32'd20, 32'd30, 16'd4, 32'd5, 32'd7, 1'b0, 1'b0, 7, 1'b0, 1'b0, "after_rst");

    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout actual=expired expected=finished");
    $fatal(1, "time bound expired");
  end

endmodule
